bank_arbiter: RTL and testbench

BANK_ARBITER -- requirements
Module: bank_arbiter

---
 rtl/bank_arbiter.sv | 129 ++++++++++++
 tb/tb_bank_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bank_arbiter.sv
// Four-requester round-robin arbiter with burst lock in front of a single-port,
// four-bank memory. Reads return one cycle after the granted transfer.
//
// state   | meaning
// S_IDLE  | no burst held; winner chosen round-robin starting at ptr
// S_BURST | owner holds the port while req/req_lock stay high, up to BURST_MAX
module bank_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              req,
  input  logic [3:0]              req_lock,
  input  logic [3:0]              req_we,
  input  logic [7:0]              req_bank,
  input  logic [4*ADDR_WIDTH-1:0] req_addr,
  input  logic [4*DATA_WIDTH-1:0] req_din,
  output logic [3:0]              gnt,
  output logic                    mem_we,
  output logic [1:0]              mem_bank_sel,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_id,
  output logic [DATA_WIDTH-1:0]   rsp_data
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] owner, owner_nxt;
  logic [3:0] burst_cnt, burst_cnt_nxt;
  logic       rsp_valid_nxt;
  logic [1:0] rsp_id_nxt;

  logic       hold;
  logic       win_vld;
  logic [1:0] win;
  logic       grant_ok;
  logic [3:0] new_cnt;

  // Winner: the burst owner while it keeps req and lock, else first req from ptr.
  always_comb begin
    hold    = (state == S_BURST) && req[owner] && req_lock[owner];
    win_vld = 1'b0;
    win     = ptr;
    if (hold) begin
      win_vld = 1'b1;
      win     = owner;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (req[ptr + 2'(i)]) begin
          win_vld = 1'b1;
          win     = ptr + 2'(i);
        end
      end
    end
    grant_ok = win_vld && rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= 2'd0;
      owner     <= 2'd0;
      burst_cnt <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 2'd0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
    end
  end

  // ptr always moves past the winner; it only matters once the burst releases.
  always_comb begin
    state_nxt     = S_IDLE;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    burst_cnt_nxt = 4'd0;
    rsp_valid_nxt = 1'b0;
    rsp_id_nxt    = rsp_id;
    new_cnt       = hold ? burst_cnt + 4'd1 : 4'd1;
    if (grant_ok) begin
      ptr_nxt = win + 2'd1;
      if (!req_we[win]) begin
        rsp_valid_nxt = 1'b1;
        rsp_id_nxt    = win;
      end
      if (req_lock[win] && (new_cnt < BURST_LIMIT)) begin
        state_nxt     = S_BURST;
        owner_nxt     = win;
        burst_cnt_nxt = new_cnt;
      end
    end
  end

  always_comb begin
    gnt          = 4'b0000;
    mem_we       = 1'b0;
    mem_bank_sel = 2'd0;
    mem_addr     = '0;
    mem_din      = '0;
    if (grant_ok) begin
      gnt[win] = 1'b1;
      mem_we   = req_we[win];
      for (int k = 0; k < 4; k++) begin
        if (win == 2'(k)) begin
          mem_bank_sel = req_bank[2*k +: 2];
          mem_addr     = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
          mem_din      = req_din[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign rsp_data = mem_dout;

endmodule

// File: tb/tb_bank_arbiter.sv
// Directed vector table plus hand sequences and a randomized scoreboard run
// for bank_arbiter with a registered-read memory model.
module tb_bank_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int BM = 4;
  localparam int WAIT_LIMIT = 3*BM + 3;
  localparam int NVEC = 19;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req, req_lock, req_we;
  logic [7:0]    req_bank;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_din;
  logic [3:0]    gnt;
  logic          mem_we;
  logic [1:0]    mem_bank_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_data;

  int checks = 0;
  int failures = 0;

  bank_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_din(req_din), .gnt(gnt),
    .mem_we(mem_we), .mem_bank_sel(mem_bank_sel), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with registered read data.
  logic [DW-1:0] mem_arr [0:63];
  always @(posedge clk) begin
    if (mem_we) mem_arr[{mem_bank_sel, mem_addr}] <= mem_din;
    mem_dout <= mem_arr[{mem_bank_sel, mem_addr}];
  end

  typedef struct {
    logic [3:0] rq;
    logic [3:0] lk;
    logic [3:0] we;
    logic [3:0] exp_gnt;
  } vec_t;
  vec_t vt [0:NVEC-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [3:0]    r_req, r_lock, r_we, g, g_prev;
  logic [1:0]    r_bank [0:3];
  logic [AW-1:0] r_addr [0:3];
  logic [DW-1:0] r_din  [0:3];
  int            wait_cnt [0:3];
  logic [DW-1:0] sb       [0:63];
  logic          sb_known [0:63];
  logic          pend_v, pend_known;
  logic [1:0]    pend_id;
  logic [DW-1:0] pend_data;
  logic          exp_rsp;
  int            w;

  initial begin
    vt[0]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001};
    vt[1]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010};
    vt[2]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0100};
    vt[3]  = '{4'b1111, 4'b0000, 4'b0000, 4'b1000};
    vt[4]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0001};
    vt[5]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0001};
    vt[6]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0001};
    vt[7]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0001};
    vt[8]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0010};
    vt[9]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0001};
    vt[10] = '{4'b1001, 4'b1000, 4'b0000, 4'b1000};
    vt[11] = '{4'b1001, 4'b1000, 4'b0000, 4'b1000};
    vt[12] = '{4'b1001, 4'b0000, 4'b0000, 4'b0001};
    vt[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vt[14] = '{4'b0110, 4'b0100, 4'b0000, 4'b0010};
    vt[15] = '{4'b0110, 4'b0100, 4'b0000, 4'b0100};
    vt[16] = '{4'b0110, 4'b0100, 4'b0000, 4'b0100};
    vt[17] = '{4'b0010, 4'b0100, 4'b0000, 4'b0010};
    vt[18] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100};

    // Reset with all requests pending: no grant, no write, no response.
    rst_n = 1'b0; req = 4'b1111; req_lock = 4'b0; req_we = 4'b1111;
    req_bank = 8'hE4; req_addr = 16'h3210; req_din = 32'h44332211;
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_mem_we", 32'(mem_we), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      req = vt[i].rq; req_lock = vt[i].lk; req_we = vt[i].we;
      #1;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].exp_gnt));
      chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(|(vt[i].exp_gnt & vt[i].we)));
      exp_rsp = (vt[i].exp_gnt != 4'b0) && ((vt[i].exp_gnt & vt[i].we) == 4'b0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(exp_rsp));
      @(negedge clk);
    end

    // Requester 2 writes A5 to bank 3 addr 5, requester 1 reads it back.
    req = 4'b0100; req_lock = 4'b0; req_we = 4'b0100;
    req_bank = 8'b00_11_00_00; req_addr = 16'h0500; req_din = 32'h00A50000;
    #1;
    chk("wr_gnt", 32'(gnt), 32'h4);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_bank", 32'(mem_bank_sel), 32'h3);
    chk("wr_addr", 32'(mem_addr), 32'h5);
    chk("wr_din", 32'(mem_din), 32'hA5);
    @(negedge clk);
    req = 4'b0010; req_we = 4'b0000; req_bank = 8'b00_00_11_00; req_addr = 16'h0050;
    #1;
    chk("rd_gnt", 32'(gnt), 32'h2);
    chk("rd_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_id", 32'(rsp_id), 32'h1);
    chk("rd_rsp_data", 32'(rsp_data), 32'hA5);

    // Reset during a locked read burst aborts both the burst and the response.
    @(negedge clk);
    req = 4'b1000; req_lock = 4'b1000; req_we = 4'b0000;
    #1;
    chk("rb_gnt0", 32'(gnt), 32'h8);
    @(negedge clk);
    chk("rb_gnt1", 32'(gnt), 32'h8);
    chk("rb_rsp_valid", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rb_rst_gnt", 32'(gnt), 32'h0);
    chk("rb_rst_mem_we", 32'(mem_we), 32'h0);
    chk("rb_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; req = 4'b1111;
    #1;
    chk("rb_rel_gnt", 32'(gnt), 32'h1);
    chk("rb_rel_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    chk("rb_rel_rsp_id", 32'(rsp_id), 32'h0);

    // Randomized run against a scoreboard of bench-driven writes.
    @(negedge clk);
    rst_n = 1'b0; req = 4'b0; req_lock = 4'b0; req_we = 4'b0;
    for (int a = 0; a < 64; a++) begin sb[a] = '0; sb_known[a] = 1'b0; end
    for (int k = 0; k < 4; k++) begin
      wait_cnt[k] = 0; r_bank[k] = '0; r_addr[k] = '0; r_din[k] = '0;
    end
    r_req = 4'b0; r_lock = 4'b0; r_we = 4'b0; g_prev = 4'b0;
    pend_v = 1'b0; pend_known = 1'b0; pend_id = '0; pend_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (g_prev[k] || !r_req[k]) begin
          r_req[k]  = ($urandom_range(0, 3) != 0);
          r_we[k]   = 1'($urandom_range(0, 1));
          r_bank[k] = 2'($urandom_range(0, 3));
          r_addr[k] = AW'($urandom_range(0, 3));
          r_din[k]  = DW'($urandom);
          wait_cnt[k] = 0;
        end
        if ($urandom_range(0, 7) == 0) r_lock[k] = ~r_lock[k];
        req_bank[2*k +: 2]   = r_bank[k];
        req_addr[k*AW +: AW] = r_addr[k];
        req_din[k*DW +: DW]  = r_din[k];
      end
      req = r_req; req_lock = r_lock; req_we = r_we;
      #1;
      g = gnt;
      chk("rnd_onehot", 32'($onehot0(g)), 32'h1);
      chk("rnd_gnt_has_req", 32'(g & ~r_req), 32'h0);
      pend_v = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (g[k]) begin
          checks++;
          if (wait_cnt[k] > WAIT_LIMIT) begin
            failures++;
            $display("FAIL rnd_wait req%0d: waited %0d cycles limit %0d", k, wait_cnt[k], WAIT_LIMIT);
          end
          w = {r_bank[k], r_addr[k]};
          if (r_we[k]) begin
            sb[w] = r_din[k]; sb_known[w] = 1'b1;
          end else begin
            pend_v = 1'b1; pend_id = 2'(k); pend_data = sb[w]; pend_known = sb_known[w];
          end
        end else if (r_req[k]) begin
          wait_cnt[k]++;
        end
      end
      @(posedge clk); #1;
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(pend_v));
      if (pend_v) begin
        chk("rnd_rsp_id", 32'(rsp_id), 32'(pend_id));
        if (pend_known) chk("rnd_rsp_data", 32'(rsp_data), 32'(pend_data));
      end
      g_prev = g;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
